// File: rtl/piso_pkg.sv
// ----------------------------------------------------------------------------
// piso_pkg
// Shared types and helpers for the piso_stream serialiser.
//   piso_state_e : FSM state encoding (ST_IDLE / ST_SHIFT)
//   even_par()   : XOR-reduce of a word. Narrower words are zero-extended,
//                  which does not change the result.
// ----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } piso_state_e;

  function automatic logic even_par(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// ----------------------------------------------------------------------------
// piso_stream_if
// Parallel-side valid/ready handshake into the serialiser.
//   prl_in : parallel word to serialise (DATA_W bits)
//   in_vld : prl_in is valid
//   in_rdy : serialiser accepts a word this cycle (combinational)
// Modports:
//   master : the word source
//   slave  : the serialiser
// ----------------------------------------------------------------------------
interface piso_stream_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] prl_in;
  logic              in_vld;
  logic              in_rdy;

  modport master (output prl_in, output in_vld, input in_rdy);
  modport slave  (input prl_in, input in_vld, output in_rdy);

endinterface

// File: rtl/piso_stream.sv
// ----------------------------------------------------------------------------
// piso_stream
// Parallel-in / serial-out converter. Words arrive over a valid/ready
// handshake and leave one bit per clock with start/end-of-word markers.
// Back-to-back words stream with no idle cycle between them.
//
// Parameters:
//   DATA_W    : word width in bits (2..64)
//   MSB_FIRST : 0 = bit 0 goes out first, 1 = bit DATA_W-1 goes out first
//
// Optional build macro:
//   PISO_PARITY_EN : append one even-parity bit after every word. eof_o then
//                    marks the parity bit.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous, active-high reset
//   in_if : piso_stream_if.slave (prl_in, in_vld, in_rdy)
//   srl_o : serial data bit (registered)
//   vld_o : srl_o holds a valid bit (registered)
//   sof_o : first bit of a word (registered)
//   eof_o : last bit of a word (registered)
// ----------------------------------------------------------------------------
module piso_stream
  import piso_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  piso_stream_if.slave  in_if,
  output logic          srl_o,
  output logic          vld_o,
  output logic          sof_o,
  output logic          eof_o
);

`ifdef PISO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int TOTAL = DATA_W + PAR_BITS;
  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  piso_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              srl_q, srl_d;
  logic              vld_q, vld_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
`ifdef PISO_PARITY_EN
  logic              par_q, par_d;
`endif
  logic              accept;

  // A new word may load while the last bit of the previous word is on the
  // wire. Loading at that point keeps vld_o continuous.
  assign in_if.in_rdy = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & eof_q));
  assign accept       = in_if.in_vld & in_if.in_rdy;

  // NOTE: every signal written here gets a default first so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    srl_d   = 1'b0;
    vld_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif

    if (accept) begin
      // The first bit goes straight to the output. The rest of the word waits
      // in the shift register, already shifted so the next bit sits at the
      // output end.
      srl_d   = MSB_FIRST ? in_if.prl_in[DATA_W-1] : in_if.prl_in[0];
      shreg_d = MSB_FIRST ? (in_if.prl_in << 1) : (in_if.prl_in >> 1);
      cnt_d   = CNT_W'(1);
      vld_d   = 1'b1;
      sof_d   = 1'b1;
      eof_d   = (TOTAL == 1);
      state_d = ST_SHIFT;
`ifdef PISO_PARITY_EN
      par_d   = even_par(64'(in_if.prl_in));
`endif
    end else if ((state_q == ST_SHIFT) && !eof_q) begin
      // cnt_q is the index of the bit being emitted on this edge.
      vld_d   = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
      eof_d   = (cnt_q == LAST_IDX);
      srl_d   = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
      shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
`ifdef PISO_PARITY_EN
      if (cnt_q == CNT_W'(DATA_W)) begin
        srl_d = par_q;
      end
`endif
    end else if (state_q == ST_SHIFT) begin
      // The last bit retired and no word followed.
      state_d = ST_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      srl_q   <= 1'b0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      srl_q   <= srl_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign srl_o = srl_q;
  assign vld_o = vld_q;
  assign sof_o = sof_q;
  assign eof_o = eof_q;

endmodule

// File: tb/tb_piso_stream.sv
// ----------------------------------------------------------------------------
// tb_piso_stream
// Directed bench for piso_stream with DATA_W=8. Two instances are used: one
// sends the LSB first and the other sends the MSB first. Expected bit
// sequences are written as vectors where bit i is the value carried on output
// cycle i. The parity vectors are used only when PISO_PARITY_EN is defined.
// ----------------------------------------------------------------------------
module tb_piso_stream;
  import piso_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] prl;
  logic         a_vld, b_vld, sel;
  logic         a_srl, a_v, a_sof, a_eof;
  logic         b_srl, b_v, b_sof, b_eof;

  always #5 clk = ~clk;

  piso_stream_if #(.DATA_W(W)) a_if ();
  piso_stream_if #(.DATA_W(W)) b_if ();

  assign a_if.prl_in = prl;
  assign a_if.in_vld = a_vld;
  assign b_if.prl_in = prl;
  assign b_if.in_vld = b_vld;

  piso_stream #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst   (rst),
    .in_if (a_if.slave),
    .srl_o (a_srl),
    .vld_o (a_v),
    .sof_o (a_sof),
    .eof_o (a_eof)
  );

  piso_stream #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst   (rst),
    .in_if (b_if.slave),
    .srl_o (b_srl),
    .vld_o (b_v),
    .sof_o (b_sof),
    .eof_o (b_eof)
  );

  // sel picks the instance whose outputs are checked.
  wire o_srl = sel ? b_srl : a_srl;
  wire o_vld = sel ? b_v   : a_v;
  wire o_sof = sel ? b_sof : a_sof;
  wire o_eof = sel ? b_eof : a_eof;
  wire o_rdy = sel ? b_if.in_rdy : a_if.in_rdy;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic s, input logic v,
                         input logic so, input logic eo, input logic r);
    chk({tag, " srl_o"},  16'(o_srl), 16'(s));
    chk({tag, " vld_o"},  16'(o_vld), 16'(v));
    chk({tag, " sof_o"},  16'(o_sof), 16'(so));
    chk({tag, " eof_o"},  16'(o_eof), 16'(eo));
    chk({tag, " in_rdy"}, 16'(o_rdy), 16'(r));
  endtask

  // Outputs are sampled 1 ns after the rising edge. Inputs change at the same
  // point, so they are stable well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for a single accept, then check n output cycles plus the
  // idle cycle that follows.
  task automatic run_word(input logic s, input logic [W-1:0] w, input int n,
                          input logic [15:0] expv, input string tag);
    logic [15:0] e;
    e   = expv;
    sel = s;
    prl = w;
    if (s) b_vld = 1'b1;
    else   a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    b_vld = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_out($sformatf("%s c%0d", tag, i), e[i], 1'b1, i == 0, i == n - 1, i == n - 1);
      tick();
    end
    chk_out({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] v;
    sel   = 1'b0;
    prl   = '0;
    a_vld = 1'b0;
    b_vld = 1'b0;
    rst   = 1'b1;
    tick();
    tick();

    // Reset state of both instances. in_rdy must read 0 while rst is high.
    chk_out("reset lsb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sel = 1'b1;
    #1;
    chk_out("reset msb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sel = 1'b0;
    rst = 1'b0;
    #1;
    chk("rdy after reset", 16'(a_if.in_rdy), 16'd1);
    tick();

`ifndef PISO_PARITY_EN
    // 8'h1E sent LSB first: 0,1,1,1,1,0,0,0.
    run_word(1'b0, 8'h1E, 8, 16'h001E, "lsb_1e");
    // 8'h1E sent MSB first: 0,0,0,1,1,1,1,0, which is bit pattern 0111_1000.
    run_word(1'b1, 8'h1E, 8, 16'h0078, "msb_1e");

    // Back-to-back: 8'hFF, then 8'h00 with in_vld held. The second word must
    // be accepted on the eof edge, giving 16 valid cycles.
    sel   = 1'b0;
    prl   = 8'hFF;
    a_vld = 1'b1;
    tick();
    prl = 8'h00;
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("b2b c%0d", i), i < 8, 1'b1, (i == 0) || (i == 8),
              (i == 7) || (i == 15), (i == 7) || (i == 15));
      if (i == 8) a_vld = 1'b0;
      tick();
    end
    chk_out("b2b idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of 8'hA5, which sends 1,0,1,0 before the reset.
    v     = 8'hA5;
    prl   = v;
    a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("a5 c%0d", i), v[i], 1'b1, i == 0, 1'b0, 1'b0);
      if (i == 3) rst = 1'b1;
      tick();
    end
    chk_out("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst state", 16'(u_lsb.state_q), 16'(ST_IDLE));
    rst = 1'b0;
    #1;
    chk("midrst rdy", 16'(a_if.in_rdy), 16'd1);
    run_word(1'b0, 8'h01, 8, 16'h0001, "after_rst");

    // 8'h55 is offered while busy and withdrawn before eof. Only 8'hC3 may
    // appear: 1,1,0,0,0,0,1,1.
    v     = 8'hC3;
    prl   = v;
    a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("busy c%0d", i), v[i], 1'b1, i == 0, i == 7, i == 7);
      if (i == 1) begin
        prl   = 8'h55;
        a_vld = 1'b1;
      end
      if (i == 5) a_vld = 1'b0;
      tick();
    end
    chk_out("busy idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("busy idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    // 8'h07 LSB first: 1,1,1,0,0,0,0,0, then parity 1.
    run_word(1'b0, 8'h07, 9, 16'h0107, "par_07");
    // 8'h03 LSB first: 1,1,0,0,0,0,0,0, then parity 0.
    run_word(1'b0, 8'h03, 9, 16'h0003, "par_03");
    // 8'h07 MSB first: 0,0,0,0,0,1,1,1, then parity 1.
    run_word(1'b1, 8'h07, 9, 16'h01E0, "par_msb_07");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
